imem_loader: RTL



---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and IRAM write-port bundle for imem_loader.
// The master modport is the loader side; the slave modport is the host/memory/core side.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [7:0]            rxData;
    logic                  rxValid;
    logic                  rxReady;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [31:0]           memDin;
    logic                  memWren;
    logic                  cpuHold;
    logic                  done;
    logic                  error;

    modport master (
        input  rxData, rxValid,
        output rxReady, memAddr, memDin, memWren, cpuHold, done, error
    );

    modport slave (
        output rxData, rxValid,
        input  rxReady, memAddr, memDin, memWren, cpuHold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader that writes 32-bit words into IRAM and holds the core meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader #(
    parameter int unsigned           ADDR_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter logic [7:0]            START_BYTE    = 8'hA5,
    parameter bit                    HOLD_AT_RESET = 1'b1
) (
    input  logic          clock,
    input  logic          clear,
    imem_loader_if.master bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_DONE} state_e;
`endif

    state_e                state_q, state_d;
    logic                  rx_ready_q, rx_ready_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_din_q, mem_din_d;
    logic                  mem_wren_q, mem_wren_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic [7:0]            count_q, count_d;
    logic [7:0]            word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           word_sr_q, word_sr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
    logic                  error_q, error_d;
`endif

    logic accept;
    logic last_word;

    assign accept    = bus.rxValid && rx_ready_q;
    // A count byte of 0 wraps to 255 here, which is how N=0 means 256 words.
    assign last_word = (word_idx_q == count_q - 8'd1);

    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_wren_d = 1'b0;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_sr_d  = word_sr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
        error_d    = error_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept && bus.rxData == START_BYTE) begin
                    state_d    = S_COUNT;
                    cpu_hold_d = 1'b1;
                end
            end

            S_COUNT: begin
                if (accept) begin
                    count_d    = bus.rxData;
                    word_idx_d = '0;
                    byte_idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = S_DATA;
                end
            end

            S_DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rxData;
`endif
                    // Little-endian assembly: earlier bytes shift toward bit 0.
                    word_sr_d  = {bus.rxData, word_sr_q[23:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_wren_d = 1'b1;
                        mem_addr_d = BASE_ADDR + ADDR_WIDTH'(word_idx_q);
                        mem_din_d  = {bus.rxData, word_sr_q};
                        word_idx_d = word_idx_q + 8'd1;
                        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (bus.rxData == csum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        error_d    = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERROR: begin
                if (accept && bus.rxData == START_BYTE) begin
                    state_d    = S_COUNT;
                    error_d    = 1'b0;
                    cpu_hold_d = 1'b1;
                end
            end
`else
            // DONE spans the final write cycle, so done lands one cycle after memWren.
            S_DONE: begin
                state_d    = S_IDLE;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
            end
`endif

            default: state_d = S_IDLE;
        endcase

        // Ready is decoded from the next state so it is registered like every other output.
        rx_ready_d = (state_d != S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_din_q  <= '0;
            mem_wren_q <= 1'b0;
            cpu_hold_q <= HOLD_AT_RESET;
            done_q     <= 1'b0;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_sr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wren_q <= mem_wren_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_sr_q  <= word_sr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            error_q    <= error_d;
`endif
        end
    end

    assign bus.rxReady = rx_ready_q;
    assign bus.memAddr = mem_addr_q;
    assign bus.memDin  = mem_din_q;
    assign bus.memWren = mem_wren_q;
    assign bus.cpuHold = cpu_hold_q;
    assign bus.done    = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.error   = error_q;
`else
    assign bus.error   = 1'b0;
`endif

endmodule
